// File: rtl/conv_sched_pkg.sv
// Shared types and sizing helpers for the convolution layer scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAITBANK,
        START,
        RUN,
        SWAP
    } state_t;

    // Keeps every derived width at least one bit so degenerate sizes still elaborate.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wt_words(input int filter_l, input int img_d);
        return filter_l * filter_l * img_d;
    endfunction

    function automatic int wt_addr_w(input int filter_l, input int img_d, input int num_pass);
        return clog2_min1(wt_words(filter_l, img_d) * num_pass);
    endfunction

endpackage

// File: rtl/conv_wt_loader.sv
// Weight-load counter; write enable/index trail the read address by one cycle (BRAM latency).
// No backpressure: counts one word per enabled cycle and holds on the final word.
module conv_wt_loader
    import conv_sched_pkg::*;
#(
    parameter int WORDS = 36,
    parameter int CNT_W = clog2_min1(WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             wren,
    output logic [CNT_W-1:0] wraddr
);

    assign last = (cnt == CNT_W'(WORDS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            wren   <= 1'b0;
            wraddr <= '0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (en && !last) begin
                cnt <= cnt + CNT_W'(1);
            end
            wren   <= en;
            wraddr <= cnt;
        end
    end

endmodule

// File: rtl/conv_layer_sched.sv
// Per-layer scheduler: loads each pass's weights, waits for a free result bank, runs the conv engine.
// Stalls in WAITBANK while the target bank is unconsumed and in START until conv_rdy.
module conv_layer_sched
    import conv_sched_pkg::*;
#(
    parameter int  FILTER_L      = 3,
    parameter int  IMG_D         = 4,
    parameter int  NUM_PASS      = 4,
    parameter int  RESULT_ADDR_W = 8,
    localparam int WT_WORDS      = wt_words(FILTER_L, IMG_D),
    localparam int WT_ADDR_W     = wt_addr_w(FILTER_L, IMG_D, NUM_PASS),
    localparam int WT_IDX_W      = clog2_min1(WT_WORDS),
    localparam int PASS_W        = clog2_min1(NUM_PASS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_val,
    output logic                 start_rdy,
    output logic                 layer_done,
    output logic [WT_ADDR_W-1:0] wt_rdaddr,
    output logic [WT_IDX_W-1:0]  wt_wraddr,
    output logic                 wt_wren,
    output logic                 conv_val,
    input  logic                 conv_rdy,
    input  logic                 conv_last,
    output logic                 bank_sel,
    output logic [1:0]           bank_full,
    input  logic [1:0]           bank_release,
    output logic [PASS_W-1:0]    pass_idx
);

    // Result addressing lives downstream; the width is only sanity-checked here.
    if (NUM_PASS < 1 || RESULT_ADDR_W < 1) begin : g_bad_param
        $error("conv_layer_sched: NUM_PASS and RESULT_ADDR_W must be at least 1");
    end

    state_t              state;
    state_t              state_nxt;
    logic                ld_clr;
    logic                ld_en;
    logic                ld_last;
    logic [WT_IDX_W-1:0] ld_cnt;
    logic                last_pass;
    logic [1:0]          set_mask;

    conv_wt_loader #(
        .WORDS (WT_WORDS),
        .CNT_W (WT_IDX_W)
    ) u_loader (
        .clk    (clk),
        .reset  (reset),
        .clr    (ld_clr),
        .en     (ld_en),
        .cnt    (ld_cnt),
        .last   (ld_last),
        .wren   (wt_wren),
        .wraddr (wt_wraddr)
    );

    assign ld_en     = (state == LOAD);
    assign last_pass = (pass_idx == PASS_W'(NUM_PASS - 1));
    assign set_mask  = (state == SWAP) ? (2'b01 << bank_sel) : 2'b00;
    assign wt_rdaddr = WT_ADDR_W'(pass_idx) * WT_ADDR_W'(WT_WORDS) + WT_ADDR_W'(ld_cnt);

    always_comb begin
        state_nxt  = state;
        ld_clr     = 1'b0;
        start_rdy  = 1'b0;
        conv_val   = 1'b0;
        layer_done = 1'b0;
        case (state)
            IDLE: begin
                start_rdy = 1'b1;
                if (start_val) begin
                    ld_clr    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (ld_last) state_nxt = WAITBANK;
            end
            WAITBANK: begin
                // wt_wren still high means the last BRAM word is being written this cycle.
                if (!bank_full[bank_sel] && !wt_wren) state_nxt = START;
            end
            START: begin
                conv_val = 1'b1;
                if (conv_rdy) state_nxt = RUN;
            end
            RUN: begin
                if (conv_last) state_nxt = SWAP;
            end
            SWAP: begin
                if (last_pass) begin
                    layer_done = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    ld_clr    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pass_idx  <= '0;
            bank_sel  <= 1'b0;
            bank_full <= 2'b00;
        end else begin
            state     <= state_nxt;
            // A set in the same cycle as a release of that bank wins.
            bank_full <= (bank_full & ~bank_release) | set_mask;
            if (state == IDLE && start_val) begin
                pass_idx <= '0;
                bank_sel <= 1'b0;
            end else if (state == SWAP) begin
                bank_sel <= ~bank_sel;
                if (!last_pass) pass_idx <= pass_idx + PASS_W'(1);
            end
        end
    end

endmodule

// File: doc/conv_layer_sched.md
CONV_LAYER_SCHED -- requirements
Module: conv_layer_sched

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 - FILTER_L, 3, filter length
 - IMG_D, 4, image depth
 - NUM_PASS, 4, number of filter-group passes per layer
 - RESULT_ADDR_W, 8, result-bank address width
REQ-002 Derived constants SHALL be:
 - WT_WORDS = FILTER_L*FILTER_L*IMG_D
 - WT_ADDR_W = $clog2(WT_WORDS*NUM_PASS)
 - PASS_W = $clog2(NUM_PASS)
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
 - clk, in, 1, sole clock, rising edge
 - reset, in, 1, asynchronous active-low reset (0 = reset)
 - start_val, in, 1, host layer request
 - start_rdy, out, 1, scheduler idle and able to accept a layer
 - layer_done, out, 1, one-cycle pulse when the final pass completes
 - wt_rdaddr, out, WT_ADDR_W, weight-store BRAM read address
 - wt_wraddr, out, $clog2(WT_WORDS), dpath weight register index
 - wt_wren, out, 1, dpath weight write enable
 - conv_val, out, 1, start request to the conv controller
 - conv_rdy, in, 1, conv controller idle
 - conv_last, in, 1, conv controller final-result pulse
 - bank_sel, out, 1, result ping-pong bank written by the current pass
 - bank_full, out, 2, per-bank holds-unconsumed-results flags
 - bank_release, in, 2, consumer per-bank release pulses
 - pass_idx, out, PASS_W, current pass number

Function
REQ-004 States SHALL be IDLE, LOAD, WAITBANK, START, RUN and SWAP; the state enum SHALL be in the shared package.
REQ-005 IDLE: start_rdy=1; start_val=1 SHALL clear pass_idx and the load counter, set bank_sel=0 and go to LOAD.
REQ-006 LOAD: the load counter SHALL step 0..WT_WORDS-1, one per cycle.
 - wt_rdaddr = pass_idx*WT_WORDS + counter.
 - After the final word the FSM SHALL go to WAITBANK.
REQ-007 wt_wren and wt_wraddr SHALL be the LOAD-valid flag and counter delayed exactly one cycle, matching BRAM read latency; the last write occurs in the first WAITBANK cycle.
REQ-008 WAITBANK SHALL hold until bank_full[bank_sel]=0 and at least one cycle has elapsed since LOAD, then go to START.
REQ-009 START SHALL drive conv_val=1 until a cycle with conv_rdy=1 (handshake), then go to RUN.
REQ-010 RUN SHALL wait for conv_last=1, then go to SWAP; conv_last outside RUN SHALL be ignored.
REQ-011 SWAP (one cycle) SHALL:
 - set bank_full[bank_sel]
 - toggle bank_sel
 - if pass_idx==NUM_PASS-1, pulse layer_done and go to IDLE
 - otherwise increment pass_idx, clear the load counter and go to LOAD
REQ-012 bank_release[b]=1 SHALL clear bank_full[b] in any state.
REQ-013 A set and a release of the same bank in the same cycle SHALL leave the flag set.
REQ-014 start_val outside IDLE SHALL be ignored.
REQ-015 When NUM_PASS=1, pass_idx SHALL be constant 0.

Reset
REQ-016 While reset=0, asynchronously and with no clock:
 - state=IDLE
 - all counters, pass_idx, bank_sel and bank_full = 0
 - all pipeline delay registers = 0
 - wt_wren=conv_val=layer_done=0
 - start_rdy=1
REQ-017 Reset asserted mid-LOAD or mid-RUN SHALL abort the layer; the first cycle after release SHALL be IDLE, with no wt_wren and no conv_val issued.

Structure
REQ-018 The state_t enum and the WT_WORDS and WT_ADDR_W helper functions SHALL reside in package conv_sched_pkg.
REQ-019 The weight-load counter and its one-cycle wren/wraddr delay SHALL be one sub-module, conv_wt_loader; all other logic SHALL be in the top module.

Verification (FILTER_L=3, IMG_D=2, NUM_PASS=3; WT_WORDS=18)
REQ-020 Single layer, consumer releases immediately:
 - pass 0: wt_rdaddr 0..17 over 18 cycles; wt_wren high cycles 1..18.
 - pass 1 starts at rdaddr 18; pass 2 at rdaddr 36.
 - Exactly 3 conv handshakes, then layer_done once.
REQ-021 Consumer never releases: pass 2 SHALL stall in WAITBANK with bank_full=2'b11 and conv_val=0; releasing bank 0 SHALL cause START within 2 cycles.
REQ-022 conv_rdy held low 5 cycles in START: conv_val SHALL stay high 6 cycles; RUN is entered the cycle after the handshake.
REQ-023 bank_release[0] in the same cycle SWAP sets bank 0: bank_full[0] SHALL read 1.
REQ-024 reset=0 for one cycle at LOAD counter 9 (no clock edge needed):
 - outputs SHALL return to reset values immediately.
 - A new start_val SHALL restart the load from wt_rdaddr 0.
REQ-025 start_val pulsed during RUN SHALL have no effect; conv_last pulsed in IDLE SHALL produce no layer_done.
